counter_sliced_param: RTL and testbench

- Parametrised successor to the fixed 32-bit counter with a 16-bit half-select display.
- WIDTH-bit up/down counter with synchronous load, programmable terminal value, terminal-count pulse and sticky overflow flag.
- Output is a registered SLICE_W-bit window chosen by `sel`.
- A hold/snapshot mechanism lets a narrow display or bus read all slices of one coherent count value.

---
 rtl/counter_sliced_param.sv | 73 +++++++
 tb/tb_counter_sliced_param.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/counter_sliced_param.sv
// counter_sliced_param: WIDTH-bit up/down counter with registered SLICE_W-bit window and hold snapshot.
// Define COUNTER_PRESCALE_EN to add a PRESCALE-stage enable prescaler.
module counter_sliced_param #(
    parameter int WIDTH = 32,
    parameter int SLICE_W = 16,
    parameter logic [WIDTH-1:0] TERM_VAL = {WIDTH{1'b1}},
    parameter int NSLICE = WIDTH / SLICE_W,
    parameter int SEL_W = (NSLICE > 1) ? $clog2(NSLICE) : 1
`ifdef COUNTER_PRESCALE_EN
    , parameter int PRESCALE = 4
`endif
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               count_en,
    input  logic               up_dn,
    input  logic               load,
    input  logic [WIDTH-1:0]   load_val,
    input  logic               hold,
    input  logic [SEL_W-1:0]   sel,
    input  logic               clr_ovf,
    output logic [SLICE_W-1:0] q_out,
    output logic               tc,
    output logic               ovf
);
    logic [WIDTH-1:0] count, shadow, count_nxt, src, load_clamp;
    logic hold_d, step, wrap;
    logic [SLICE_W-1:0] slices [NSLICE];

`ifdef COUNTER_PRESCALE_EN
    localparam int PS_W = $clog2(PRESCALE);
    logic [PS_W-1:0] pre;
    assign step = count_en && pre == PS_W'(PRESCALE - 1);
    always_ff @(posedge clk)
        if (reset || load) pre <= '0;
        else if (count_en) pre <= step ? '0 : pre + PS_W'(1);
`else
    assign step = count_en;
`endif

    always_comb begin
        load_clamp = (load_val > TERM_VAL) ? TERM_VAL : load_val;
        wrap = !load && step && (up_dn ? count == TERM_VAL : count == '0);
        count_nxt = load ? load_clamp :
                    !step ? count :
                    wrap ? (up_dn ? '0 : TERM_VAL) :
                    up_dn ? count + WIDTH'(1) : count - WIDTH'(1);
        // the snapshot is only visible from the edge after capture onward
        src = (hold && hold_d) ? shadow : count;
    end

    for (genvar g = 0; g < NSLICE; g++) begin : g_slice
        assign slices[g] = src[g*SLICE_W +: SLICE_W];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count  <= '0;
            shadow <= '0;
            hold_d <= 1'b0;
            q_out  <= '0;
            tc     <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            count  <= count_nxt;
            tc     <= wrap;
            ovf    <= wrap || (ovf && !clr_ovf);
            hold_d <= hold;
            if (hold && !hold_d) shadow <= count;
            q_out  <= (int'(sel) < NSLICE) ? slices[sel] : '0;
        end
    end
endmodule

// File: tb/tb_counter_sliced_param.sv
// tb_counter_sliced_param: three counter configurations driven in lockstep against a behavioural model.
module tb_counter_sliced_param;
    localparam int NI = 3;
    typedef struct {
        logic [15:0] q;
        logic        tc;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1, count_en = 1'b1, up_dn = 1'b1, load = 1'b0, hold = 1'b0, clr_ovf = 1'b0;
    logic [47:0] load_val = '0;
    logic [1:0] sel = '0;
    logic [15:0] q_o [NI];
    logic tc_o [NI];
    logic ovf_o [NI];

    int ncmp = 0, nfail = 0;
    exp_t sb[$];

    // instance 0: defaults, 1: TERM_VAL=1000, 2: 48-bit with three slices
    int unsigned wid [NI] = '{32, 32, 48};
    longint unsigned term [NI] = '{64'hFFFF_FFFF, 64'd1000, 64'hFFFF_FFFF_FFFF};
    int nsl [NI] = '{2, 2, 3};
    longint unsigned m_cnt [NI], m_sh [NI];
    bit m_hd [NI], m_tc [NI], m_ovf [NI];
    logic [15:0] m_q [NI];
    int m_pre [NI];

    always #5 clk = ~clk;

    counter_sliced_param dut_a (
        .clk(clk), .reset(reset), .count_en(count_en), .up_dn(up_dn), .load(load),
        .load_val(load_val[31:0]), .hold(hold), .sel(sel[0]), .clr_ovf(clr_ovf),
        .q_out(q_o[0]), .tc(tc_o[0]), .ovf(ovf_o[0])
    );
    counter_sliced_param #(.TERM_VAL(32'd1000)) dut_b (
        .clk(clk), .reset(reset), .count_en(count_en), .up_dn(up_dn), .load(load),
        .load_val(load_val[31:0]), .hold(hold), .sel(sel[0]), .clr_ovf(clr_ovf),
        .q_out(q_o[1]), .tc(tc_o[1]), .ovf(ovf_o[1])
    );
    counter_sliced_param #(.WIDTH(48)) dut_c (
        .clk(clk), .reset(reset), .count_en(count_en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .hold(hold), .sel(sel), .clr_ovf(clr_ovf),
        .q_out(q_o[2]), .tc(tc_o[2]), .ovf(ovf_o[2])
    );

    task automatic chk(string tag, logic [47:0] obs, logic [47:0] expv);
        ncmp++;
        assert (obs === expv) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < NI; i++) begin
            longint unsigned src, lv, mask;
            int s;
            bit adv, wr;
            mask = (64'd1 << wid[i]) - 64'd1;
            s = (i == 2) ? int'(sel) : int'(sel[0]);
            if (reset) begin
                m_cnt[i] = 0; m_sh[i] = 0; m_hd[i] = 0; m_q[i] = '0;
                m_tc[i] = 0; m_ovf[i] = 0; m_pre[i] = 0;
            end else begin
                src = (hold && m_hd[i]) ? m_sh[i] : m_cnt[i];
                m_q[i] = (s < nsl[i]) ? 16'(src >> (16 * s)) : 16'h0;
                if (hold && !m_hd[i]) m_sh[i] = m_cnt[i];
                m_hd[i] = hold;
                adv = count_en;
                wr = 0;
`ifdef COUNTER_PRESCALE_EN
                if (load) m_pre[i] = 0;
                else if (count_en) begin
                    adv = (m_pre[i] == 3);
                    m_pre[i] = adv ? 0 : m_pre[i] + 1;
                end
`endif
                lv = 64'(load_val) & mask;
                if (load) m_cnt[i] = (lv > term[i]) ? term[i] : lv;
                else if (adv && up_dn) begin
                    wr = (m_cnt[i] == term[i]);
                    m_cnt[i] = wr ? 0 : m_cnt[i] + 1;
                end else if (adv) begin
                    wr = (m_cnt[i] == 0);
                    m_cnt[i] = wr ? term[i] : m_cnt[i] - 1;
                end
                m_tc[i] = wr;
                m_ovf[i] = wr || (m_ovf[i] && !clr_ovf);
            end
            sb.push_back('{m_q[i], m_tc[i], m_ovf[i]});
        end
    endtask

    task automatic tick(string tag);
        exp_t e;
        model_edge();
        @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            e = sb.pop_front();
            chk($sformatf("%s/u%0d.q_out", tag, i), q_o[i], e.q);
            chk($sformatf("%s/u%0d.tc", tag, i), tc_o[i], e.tc);
            chk($sformatf("%s/u%0d.ovf", tag, i), ovf_o[i], e.ovf);
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            tick("reset");
            chk("reset_q", q_o[0], 0);
            chk("reset_ovf", ovf_o[0], 0);
        end
        reset = 1'b0;
`ifdef COUNTER_PRESCALE_EN
        load = 1'b1; load_val = 0; count_en = 1'b0; tick("ps_load0");
        load = 1'b0; count_en = 1'b1;
        for (int k = 0; k < 5; k++) tick("ps_run1");
        count_en = 1'b0;
        for (int k = 0; k < 3; k++) tick("ps_pause");
        count_en = 1'b1;
        for (int k = 0; k < 3; k++) tick("ps_run2");
        count_en = 1'b0; tick("ps_idle");
        chk("ps_eight_edges", q_o[0], 2);
        count_en = 1'b1; tick("ps_part"); tick("ps_part");
        load = 1'b1; load_val = 0; tick("ps_reload");
        load = 1'b0;
        for (int k = 0; k < 3; k++) tick("ps_after_load");
        count_en = 1'b0; tick("ps_idle2");
        chk("ps_restart_3", q_o[0], 0);
        count_en = 1'b1; tick("ps_fourth");
        count_en = 1'b0; tick("ps_idle3");
        chk("ps_restart_4", q_o[0], 1);
`else
        for (int k = 0; k < 5; k++) begin
            tick("count_up");
            chk("lag_q", q_o[0], k);
        end
        count_en = 1'b0; load = 1'b1; load_val = 48'hFFFF_FFFE; tick("load_fffe");
        load = 1'b0; count_en = 1'b1; tick("to_ffff");
        chk("pre_wrap_tc", tc_o[0], 0);
        tick("wrap_up");
        chk("wrap_tc", tc_o[0], 1);
        chk("wrap_ovf", ovf_o[0], 1);
        count_en = 1'b0; tick("after_wrap");
        chk("tc_one_cycle", tc_o[0], 0);
        chk("ovf_sticky", ovf_o[0], 1);
        clr_ovf = 1'b1; tick("clr_ovf");
        chk("ovf_cleared", ovf_o[0], 0);
        clr_ovf = 1'b0; load = 1'b1; load_val = 48'hFFFF_FFFF; tick("load_ffff");
        load = 1'b0; count_en = 1'b1; clr_ovf = 1'b1; tick("wrap_and_clr");
        chk("set_wins_ovf", ovf_o[0], 1);
        clr_ovf = 1'b0; count_en = 1'b0;
        load = 1'b1; load_val = 0; tick("load0");
        load = 1'b0; count_en = 1'b1; up_dn = 1'b0; tick("wrap_down");
        chk("t1000_tc", tc_o[1], 1);
        count_en = 1'b0; tick("show_1000");
        chk("t1000_q", q_o[1], 1000);
        load = 1'b1; load_val = 5000; tick("load_5000");
        load = 1'b0; tick("show_clamp");
        chk("clamp_q", q_o[1], 1000);
        chk("clamp_no_tc", tc_o[1], 0);
        up_dn = 1'b1; load = 1'b1; load_val = 48'h0001_FFFF; sel = 0; tick("load_1ffff");
        load = 1'b0; hold = 1'b1; count_en = 1'b1;
        for (int k = 0; k < 10; k++) begin
            sel = (k < 5) ? 2'd0 : 2'd1;
            tick("hold_count");
            chk("snap_q", q_o[0], (k < 5) ? 16'hFFFF : 16'h0001);
        end
        hold = 1'b0; count_en = 1'b0; sel = 1; tick("live_hi");
        chk("live_hi", q_o[0], 16'h0002);
        sel = 0; tick("live_lo");
        chk("live_lo", q_o[0], 16'h0009);
        load = 1'b1; count_en = 1'b1; load_val = 48'h1234_0000_0007; tick("load_wins");
        load = 1'b0; count_en = 1'b0; tick("show7");
        chk("load_wins_q", q_o[0], 7);
        sel = 2; tick("sel2");
        chk("sel2_c", q_o[2], 16'h1234);
        sel = 3; tick("sel3");
        chk("sel_oor_c", q_o[2], 0);
        sel = 0; hold = 1'b1; count_en = 1'b1; tick("capture");
        reset = 1'b1; tick("mid_reset");
        chk("mid_reset_q", q_o[2], 0);
        reset = 1'b0; tick("post_reset");
        chk("post_reset_q", q_o[0], 0);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
